qed_dup_scheduler: RTL and testbench
====================================

# qed_dup_scheduler

Sequences Quick Error Detection (QED) instruction duplication between the fetch unit and the pipeline issue stage. Passes original instructions downstream and queues duplicable ones (I-type ALU, R-type, LW, SW) in an internal FIFO. Replays the queued instructions as a contiguous duplicate burst, so register/memory remapping logic downstream only needs the `qed_is_dup` tag. Classification uses the existing QED decoder field/flag outputs.

## Interface
- `DEPTH`, 8: duplicate FIFO entries; power of two, ≥2.
- `CNT_W`, $clog2(DEPTH+1): width of the occupancy output.
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `qed_ena` in 1: QED mode enable; sampled each cycle.
- `exec_dup` in 1: request to drain the FIFO now; single-cycle pulse or level.
- `ifu_qed_instruction` in 32: fetched instruction.
- `ifu_valid` in 1: fetched instruction valid.
- `ifu_ready` out 1: scheduler accepts fetch this cycle.
- `qed_instruction` out 32: instruction to issue; registered.
- `qed_valid` out 1: `qed_instruction` valid.
- `qed_ready` in 1: issue stage accepts.
- `qed_is_dup` out 1: issued instruction is a duplicate.
- `qed_dup_count` out CNT_W: current FIFO occupancy.
- `qed_orig_cnt` out 16, `qed_dup_cnt` out 16: statistics; see Configuration.

## Operation
- States: IDLE, ORIG, DRAIN.
  - IDLE: pass-through; nothing queued.
  - ORIG: pass originals and push duplicable ones.
  - DRAIN: `ifu_ready`=0; pop the FIFO to the output with `qed_is_dup`=1.
- Fetch acceptance:
  - A fetch is accepted when `ifu_valid && ifu_ready`.
  - `ifu_ready` = (state≠DRAIN) && (!`qed_valid` || `qed_ready`) && !`hold_j`.
- Classification:
  - Duplicable = IS_I | IS_R | IS_LW | IS_SW.
  - IS_J is a control-flow barrier.
  - Anything else passes as an original and is not pushed.
- `hold_j`: asserted when state=ORIG, the fetch is IS_J and the FIFO is non-empty. The jump is not accepted; go to DRAIN. The jump is accepted after returning to ORIG.
- Transitions:
  - IDLE→ORIG when `qed_ena`=1.
  - ORIG→DRAIN when any of the following holds:
    - an accepted push makes the FIFO full;
    - `exec_dup`=1 with FIFO non-empty;
    - `hold_j`;
    - `qed_ena`=0 with FIFO non-empty.
  - ORIG→IDLE when `qed_ena`=0 and the FIFO is empty.
  - DRAIN→ORIG when the last entry pops and `qed_ena`=1.
  - DRAIN→IDLE when the last entry pops and `qed_ena`=0.
- `exec_dup` with an empty FIFO is ignored.
- `qed_ena` dropping mid-DRAIN does not abort the drain.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. Full/empty use an extra wrap bit. Never push when full; never pop when empty.
- Push and pop never occur in the same cycle: push happens only in ORIG, pop only in DRAIN.

## Timing
- Reset values:
  - state=IDLE; FIFO pointers 0.
  - `qed_valid`=0, `qed_instruction`=0, `qed_is_dup`=0, `qed_dup_count`=0.
  - Statistics counters 0; `ifu_ready` follows its equation, which evaluates to 1 after reset.
- Latency:
  - An accepted fetch appears on `qed_instruction` the next cycle.
  - In DRAIN, one duplicate is issued per cycle while `qed_ready`=1.
  - The first duplicate appears one cycle after entering DRAIN.
- The output register holds its value while `qed_valid && !qed_ready`.
- State transitions take effect on the edge following the triggering condition.
- `qed_dup_count` updates on the same edge as the push or pop.
- Reset mid-burst discards all queued entries and any in-flight output immediately.

## Configuration
- `QED_DUP_STATS_EN` defined:
  - `qed_orig_cnt` increments on each issued original (`qed_valid && qed_ready && !qed_is_dup`).
  - `qed_dup_cnt` increments on each issued duplicate.
  - Both saturate at 16'hFFFF.
- `QED_DUP_STATS_EN` undefined: both ports are tied to 0 and no counter flops exist.

## Structure
- Shared package `qed_pkg` holds:
  - opcode constants (0010011, 0110011, 0000011, 0100011, 1101111);
  - FUNCT3_W = 3'b010;
  - the state enum `qed_sched_state_t`.
- One existing decoder instance supplies IS_I/IS_R/IS_LW/IS_SW/IS_J.
- Sub-module `qed_dup_fifo`:
  - DEPTH×32 storage with push/pop;
  - full, empty and count outputs;
  - asynchronous reset on pointers only.

## Test plan
- Reset → `qed_valid`=0, `qed_dup_count`=0, state IDLE. With `qed_ena`=0, ADDI 0x00100093 is issued next cycle with `qed_is_dup`=0.
- Full-FIFO burst: `qed_ena`=1, 8 consecutive R-type 0x002081B3 → 8 originals, `ifu_ready`=0 for 8 cycles, then 8 duplicates with `qed_is_dup`=1. `qed_dup_count` goes 8→0.
- Jump barrier: 3 LW 0x0000A103, then JAL 0x0080006F → JAL held, 3 duplicates issued, then JAL issued as an original.
- `exec_dup` pulse after 2 SW 0x0020A023 → 2 duplicates drained. `exec_dup` with an empty FIFO → no state change.
- Backpressure: `qed_ready`=0 for 5 cycles mid-DRAIN → output stable, count frozen, no loss or duplication.
- Async `rst` pulse mid-DRAIN with count=4 → count=0, `qed_valid`=0 before the next edge. With `QED_DUP_STATS_EN` defined, counters also clear to 0.

Source files
------------

// File: rtl/qed_pkg.sv
// Shared QED definitions: RISC-V opcodes used for duplicate classification,
// scheduler state encoding and the issue-slot record.
package qed_pkg;

    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [2:0] FUNCT3_W  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ORIG,
        ST_DRAIN
    } qed_sched_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        is_dup;
    } qed_issue_t;

endpackage

// File: rtl/qed_dup_scheduler_if.sv
// Fetch-side and issue-side handshake bundle of the QED duplicate scheduler.
// The scheduler uses the slave modport; the fetch/issue environment the master.
interface qed_dup_scheduler_if #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
);
    logic              qed_ena;
    logic              exec_dup;
    logic [31:0]       ifu_qed_instruction;
    logic              ifu_valid;
    logic              ifu_ready;
    logic [31:0]       qed_instruction;
    logic              qed_valid;
    logic              qed_ready;
    logic              qed_is_dup;
    logic [CNT_W-1:0]  qed_dup_count;
    logic [15:0]       qed_orig_cnt;
    logic [15:0]       qed_dup_cnt;

    modport slave (
        input  qed_ena, exec_dup, ifu_qed_instruction, ifu_valid, qed_ready,
        output ifu_ready, qed_instruction, qed_valid, qed_is_dup,
               qed_dup_count, qed_orig_cnt, qed_dup_cnt
    );

    modport master (
        output qed_ena, exec_dup, ifu_qed_instruction, ifu_valid, qed_ready,
        input  ifu_ready, qed_instruction, qed_valid, qed_is_dup,
               qed_dup_count, qed_orig_cnt, qed_dup_cnt
    );
endinterface

// File: rtl/qed_decoder.sv
// QED instruction decoder: flags the instruction classes that matter for
// duplication (I-type ALU, R-type, LW, SW) and the JAL control-flow barrier.
module qed_decoder
    import qed_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output logic       is_i,
    output logic       is_r,
    output logic       is_lw,
    output logic       is_sw,
    output logic       is_j
);
    assign is_i  = (opcode == OPC_I);
    assign is_r  = (opcode == OPC_R);
    assign is_lw = (opcode == OPC_LOAD)  && (funct3 == FUNCT3_W);
    assign is_sw = (opcode == OPC_STORE) && (funct3 == FUNCT3_W);
    assign is_j  = (opcode == OPC_JAL);
endmodule

// File: rtl/qed_dup_fifo.sv
// Duplicate queue: DEPTH x 32 storage, pointers carry an extra wrap bit so
// full and empty are distinguishable. Only the pointers are reset.
module qed_dup_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [31:0]      wdata,
    input  logic             pop,
    output logic [31:0]      rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [31:0] mem [DEPTH];
    logic [AW:0] wptr, rptr, occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)  wptr <= wptr + PTR_ONE;
            if (pop  && !empty) rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign occ   = wptr - rptr;
    assign count = CNT_W'(occ);
endmodule

// File: rtl/qed_dup_scheduler.sv
// QED duplicate scheduler: issues originals, queues duplicable ones and
// replays them as a tagged burst. Define QED_DUP_STATS_EN for issue counters.
module qed_dup_scheduler
    import qed_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    qed_dup_scheduler_if.slave bus
);
    qed_sched_state_t state, state_nxt;
    qed_issue_t       issue_q;
    logic             valid_q;
    logic             is_i, is_r, is_lw, is_sw, is_j, dupable;
    logic             hold_j, ifu_rdy, acc, push, pop, out_free;
    logic             fifo_full, fifo_empty;
    logic [31:0]      fifo_rdata;
    logic [CNT_W-1:0] fifo_count;

    qed_decoder u_dec (
        .opcode (bus.ifu_qed_instruction[6:0]),
        .funct3 (bus.ifu_qed_instruction[14:12]),
        .is_i   (is_i),
        .is_r   (is_r),
        .is_lw  (is_lw),
        .is_sw  (is_sw),
        .is_j   (is_j)
    );

    qed_dup_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (bus.ifu_qed_instruction),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign dupable  = is_i | is_r | is_lw | is_sw;
    assign out_free = !valid_q || bus.qed_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // A push that lands while qed_ena drops still has to be drained, so the
    // ORIG exit looks at occupancy including this cycle's push.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.qed_ena) state_nxt = ST_ORIG;
            ST_ORIG: begin
                if (hold_j
                    || (push && fifo_count == CNT_W'(DEPTH - 1))
                    || (bus.exec_dup && !fifo_empty)
                    || (!bus.qed_ena && (!fifo_empty || push)))
                    state_nxt = ST_DRAIN;
                else if (!bus.qed_ena)
                    state_nxt = ST_IDLE;
            end
            ST_DRAIN: if (pop && fifo_count == CNT_W'(1))
                state_nxt = bus.qed_ena ? ST_ORIG : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        hold_j  = (state == ST_ORIG) && bus.ifu_valid && is_j && !fifo_empty;
        ifu_rdy = (state != ST_DRAIN) && out_free && !hold_j;
        acc     = bus.ifu_valid && ifu_rdy;
        push    = (state == ST_ORIG) && acc && dupable && !fifo_full;
        pop     = (state == ST_DRAIN) && out_free && !fifo_empty;
    end

    // acc and pop are exclusive: fetch is never accepted in DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            issue_q <= '0;
        end else if (acc) begin
            valid_q <= 1'b1;
            issue_q <= '{instr: bus.ifu_qed_instruction, is_dup: 1'b0};
        end else if (pop) begin
            valid_q <= 1'b1;
            issue_q <= '{instr: fifo_rdata, is_dup: 1'b1};
        end else if (bus.qed_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.ifu_ready       = ifu_rdy;
    assign bus.qed_valid       = valid_q;
    assign bus.qed_instruction = issue_q.instr;
    assign bus.qed_is_dup      = issue_q.is_dup;
    assign bus.qed_dup_count   = fifo_count;

`ifdef QED_DUP_STATS_EN
    logic [15:0] orig_cnt, dup_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            orig_cnt <= '0;
            dup_cnt  <= '0;
        end else if (valid_q && bus.qed_ready) begin
            if (issue_q.is_dup) begin
                if (dup_cnt != 16'hFFFF) dup_cnt <= dup_cnt + 16'd1;
            end else begin
                if (orig_cnt != 16'hFFFF) orig_cnt <= orig_cnt + 16'd1;
            end
        end
    end

    assign bus.qed_orig_cnt = orig_cnt;
    assign bus.qed_dup_cnt  = dup_cnt;
`else
    assign bus.qed_orig_cnt = '0;
    assign bus.qed_dup_cnt  = '0;
`endif
endmodule

// File: tb/tb_qed_dup_scheduler.sv
// Bench for qed_dup_scheduler: directed scenarios plus randomized fetch
// streams checked against a stream-level model of original/duplicate order.
module tb_qed_dup_scheduler;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [31:0] instr;
        logic        dup;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   lowrdy, maxcnt, tot_orig, tot_dup;
    item_t       got_q[$];
    item_t       exp_q[$];
    logic [31:0] stim_q[$];

    qed_dup_scheduler_if #(.DEPTH(DEPTH)) bus ();
    qed_dup_scheduler #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Monitor: a transfer seen at negedge completes on the following posedge.
    always @(negedge clk) begin
        if (rst) begin
            tot_orig = 0;
            tot_dup  = 0;
        end else begin
            if (bus.qed_valid && bus.qed_ready) begin
                got_q.push_back('{bus.qed_instruction, bus.qed_is_dup});
                if (bus.qed_is_dup) tot_dup++;
                else tot_orig++;
            end
            if (!bus.ifu_ready) lowrdy++;
            if (int'(bus.qed_dup_count) > maxcnt) maxcnt = int'(bus.qed_dup_count);
        end
    end

    function automatic bit is_dupable(input logic [31:0] i);
        return (i[6:0] == 7'h13) || (i[6:0] == 7'h33) ||
               (i[6:0] == 7'h03 && i[14:12] == 3'd2) ||
               (i[6:0] == 7'h23 && i[14:12] == 3'd2);
    endfunction

    function automatic bit is_jal(input logic [31:0] i);
        return i[6:0] == 7'h6F;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(8))
            0: r[6:0] = 7'h33;
            1: r[6:0] = 7'h13;
            2: begin r[6:0] = 7'h03; r[14:12] = 3'd2; end
            3: begin r[6:0] = 7'h03; r[14:12] = 3'd1; end
            4: begin r[6:0] = 7'h23; r[14:12] = 3'd2; end
            5: begin r[6:0] = 7'h23; r[14:12] = 3'd0; end
            6: r[6:0] = 7'h6F;
            7: r[6:0] = 7'h37;
            default: r[6:0] = 7'h63;
        endcase
        return r;
    endfunction

    // Expected issue order from the fetch stream alone: every fetch is
    // issued as an original; the pending queue is replayed when it fills,
    // before a jump, and once at the end when QED is switched off.
    task automatic build_exp();
        logic [31:0] pend[$];
        exp_q.delete();
        foreach (stim_q[k]) begin
            if (is_jal(stim_q[k]) && pend.size() > 0) begin
                foreach (pend[j]) exp_q.push_back('{pend[j], 1'b1});
                pend.delete();
            end
            exp_q.push_back('{stim_q[k], 1'b0});
            if (is_dupable(stim_q[k])) begin
                pend.push_back(stim_q[k]);
                if (pend.size() == DEPTH) begin
                    foreach (pend[j]) exp_q.push_back('{pend[j], 1'b1});
                    pend.delete();
                end
            end
        end
        foreach (pend[j]) exp_q.push_back('{pend[j], 1'b1});
    endtask

    task automatic start_orig();
        bus.qed_ena = 1'b1; bus.ifu_valid = 1'b0; bus.qed_ready = 1'b1; bus.exec_dup = 1'b0;
        @(posedge clk); #1;
        got_q.delete(); lowrdy = 0; maxcnt = 0;
    endtask

    task automatic feed(input int vpct, input int rpct);
        int idx = 0;
        int cyc = 0;
        while (idx < stim_q.size() && cyc < 2000) begin
            bus.ifu_valid = ($urandom_range(99) < vpct);
            bus.ifu_qed_instruction = stim_q[idx];
            bus.qed_ready = ($urandom_range(99) < rpct);
            @(negedge clk);
            if (bus.ifu_valid && bus.ifu_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (idx != stim_q.size()) begin
            errors++;
            $display("FAIL feed_accept: accepted %0d expected %0d", idx, stim_q.size());
        end
        bus.ifu_valid = 1'b0;
    endtask

    task automatic finish_idle(input int rpct);
        int cyc = 0;
        bus.qed_ena = 1'b0;
        while ((bus.qed_dup_count != 0 || bus.qed_valid) && cyc < 500) begin
            bus.qed_ready = ($urandom_range(99) < rpct);
            @(posedge clk); #1;
            cyc++;
        end
        bus.qed_ready = 1'b1;
        checks++;
        if (bus.qed_valid !== 1'b0 || bus.qed_dup_count !== 0) begin
            errors++;
            $display("FAIL drain_idle: valid=%0b count=%0d expected 0/0", bus.qed_valid, bus.qed_dup_count);
        end
        build_exp();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.qed_ena = 1'b0; bus.exec_dup = 1'b0; bus.ifu_valid = 1'b0;
        bus.ifu_qed_instruction = '0; bus.qed_ready = 1'b1;
        #12 rst = 1'b0;
        #1;
        checks++;
        if (bus.qed_valid !== 1'b0 || bus.qed_instruction !== 32'h0 || bus.qed_is_dup !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: valid=%0b instr=%h dup=%0b expected 0/0/0", bus.qed_valid, bus.qed_instruction, bus.qed_is_dup);
        end
        checks++;
        if (bus.qed_dup_count !== 0 || bus.ifu_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: count=%0d ifu_ready=%0b expected 0/1", bus.qed_dup_count, bus.ifu_ready);
        end
        checks++;
        if (bus.qed_orig_cnt !== 16'h0 || bus.qed_dup_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_stats: orig=%0d dup=%0d expected 0/0", bus.qed_orig_cnt, bus.qed_dup_cnt);
        end
        bus.ifu_valid = 1'b1; bus.ifu_qed_instruction = 32'h00100093;
        @(posedge clk); #1;
        bus.ifu_valid = 1'b0;
        checks++;
        if (bus.qed_valid !== 1'b1 || bus.qed_instruction !== 32'h00100093 || bus.qed_is_dup !== 1'b0) begin
            errors++;
            $display("FAIL passthrough: valid=%0b instr=%h dup=%0b expected 1/00100093/0", bus.qed_valid, bus.qed_instruction, bus.qed_is_dup);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.qed_valid !== 1'b0 || bus.qed_dup_count !== 0) begin
            errors++;
            $display("FAIL passthrough_noqueue: valid=%0b count=%0d expected 0/0", bus.qed_valid, bus.qed_dup_count);
        end
    endtask

    task automatic test_full_burst();
        stim_q.delete();
        repeat (DEPTH) stim_q.push_back(32'h002081B3);
        start_orig();
        feed(100, 100);
        finish_idle(100);
        checks++;
        if (lowrdy != DEPTH) begin
            errors++;
            $display("FAIL burst_ifu_ready_low: got %0d cycles expected %0d", lowrdy, DEPTH);
        end
        checks++;
        if (maxcnt != DEPTH) begin
            errors++;
            $display("FAIL burst_peak_count: got %0d expected %0d", maxcnt, DEPTH);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL burst_len: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL burst_item %0d: got %h/%0b expected %h/%0b", k, got_q[k].instr, got_q[k].dup, exp_q[k].instr, exp_q[k].dup);
            end
        end
    endtask

    task automatic test_jump_barrier();
        stim_q = '{32'h0000A103, 32'h0000A103, 32'h0000A103, 32'h0080006F};
        start_orig();
        feed(100, 100);
        finish_idle(100);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL jump_len: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL jump_item %0d: got %h/%0b expected %h/%0b", k, got_q[k].instr, got_q[k].dup, exp_q[k].instr, exp_q[k].dup);
            end
        end
    endtask

    task automatic test_exec_dup();
        int cyc = 0;
        stim_q = '{32'h0020A023, 32'h0020A023};
        start_orig();
        feed(100, 100);
        bus.exec_dup = 1'b1;
        @(posedge clk); #1;
        bus.exec_dup = 1'b0;
        while (bus.qed_dup_count != 0 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (bus.qed_dup_count !== 0) begin
            errors++;
            $display("FAIL exec_drain: count=%0d expected 0", bus.qed_dup_count);
        end
        finish_idle(100);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL exec_len: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL exec_item %0d: got %h/%0b expected %h/%0b", k, got_q[k].instr, got_q[k].dup, exp_q[k].instr, exp_q[k].dup);
            end
        end
        start_orig();
        bus.exec_dup = 1'b1;
        @(posedge clk); #1;
        bus.exec_dup = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ifu_ready !== 1'b1 || bus.qed_dup_count !== 0 || bus.qed_valid !== 1'b0) begin
            errors++;
            $display("FAIL exec_empty: ifu_ready=%0b count=%0d valid=%0b expected 1/0/0", bus.ifu_ready, bus.qed_dup_count, bus.qed_valid);
        end
        bus.qed_ena = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        stim_q.delete();
        for (int i = 0; i < DEPTH; i++) stim_q.push_back(32'h00100013 | (32'(i + 1) << 7));
        start_orig();
        feed(100, 100);
        repeat (3) @(posedge clk);
        #1 bus.qed_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (bus.qed_valid !== 1'b1 || bus.qed_is_dup !== 1'b1 || bus.qed_instruction !== stim_q[2] || bus.qed_dup_count !== DEPTH - 3) begin
                errors++;
                $display("FAIL bp_hold cyc %0d: valid=%0b dup=%0b instr=%h count=%0d expected 1/1/%h/%0d",
                         k, bus.qed_valid, bus.qed_is_dup, bus.qed_instruction, bus.qed_dup_count, stim_q[2], DEPTH - 3);
            end
        end
        @(posedge clk); #1;
        bus.qed_ready = 1'b1;
        finish_idle(100);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bp_len: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL bp_item %0d: got %h/%0b expected %h/%0b", k, got_q[k].instr, got_q[k].dup, exp_q[k].instr, exp_q[k].dup);
            end
        end
    endtask

    task automatic test_random();
        int exp_o, exp_d;
        for (int r = 0; r < 5; r++) begin
            stim_q.delete();
            repeat (30) stim_q.push_back(rand_instr());
            start_orig();
            feed((r == 0) ? 100 : 50 + 10 * r, (r == 0) ? 100 : 40 + 10 * r);
            finish_idle((r == 0) ? 100 : 60);
            checks++;
            if (got_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_len: got %0d expected %0d", r, got_q.size(), exp_q.size());
            end
            for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
                checks++;
                if (got_q[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL rand%0d_item %0d: got %h/%0b expected %h/%0b", r, k, got_q[k].instr, got_q[k].dup, exp_q[k].instr, exp_q[k].dup);
                end
            end
        end
`ifdef QED_DUP_STATS_EN
        exp_o = tot_orig; exp_d = tot_dup;
`else
        exp_o = 0; exp_d = 0;
`endif
        checks++;
        if (bus.qed_orig_cnt !== 16'(exp_o) || bus.qed_dup_cnt !== 16'(exp_d)) begin
            errors++;
            $display("FAIL stats: orig=%0d dup=%0d expected %0d/%0d", bus.qed_orig_cnt, bus.qed_dup_cnt, exp_o, exp_d);
        end
    endtask

    task automatic test_reset_mid_drain();
        stim_q.delete();
        repeat (DEPTH) stim_q.push_back(rand_instr() & 32'hFFFFFF80 | 32'h33);
        start_orig();
        feed(100, 100);
        repeat (4) @(posedge clk);
        #1 bus.qed_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.qed_dup_count !== 4 || bus.qed_is_dup !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: count=%0d dup=%0b expected 4/1", bus.qed_dup_count, bus.qed_is_dup);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.qed_dup_count !== 0 || bus.qed_valid !== 1'b0 || bus.qed_is_dup !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: count=%0d valid=%0b dup=%0b expected 0/0/0", bus.qed_dup_count, bus.qed_valid, bus.qed_is_dup);
        end
        checks++;
        if (bus.qed_orig_cnt !== 16'h0 || bus.qed_dup_cnt !== 16'h0 || bus.ifu_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_stats: orig=%0d dup=%0d ifu_ready=%0b expected 0/0/1", bus.qed_orig_cnt, bus.qed_dup_cnt, bus.ifu_ready);
        end
        bus.qed_ena = 1'b0; bus.qed_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        bus.ifu_valid = 1'b1; bus.ifu_qed_instruction = 32'h00100093;
        @(posedge clk); #1;
        bus.ifu_valid = 1'b0;
        checks++;
        if (bus.qed_valid !== 1'b1 || bus.qed_is_dup !== 1'b0 || bus.qed_instruction !== 32'h00100093 || bus.qed_dup_count !== 0) begin
            errors++;
            $display("FAIL rst_after: valid=%0b dup=%0b instr=%h count=%0d expected 1/0/00100093/0",
                     bus.qed_valid, bus.qed_is_dup, bus.qed_instruction, bus.qed_dup_count);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_jump_barrier();
        test_exec_dup();
        test_backpressure();
        test_random();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
